// File: rtl/instr_encoder.sv
// instr_encoder: packs lw/sw/beq requests into RV32I words and streams them through a 2-entry skid buffer (optional immediate range check: ENC_RANGE_CHK_EN).
module instr_encoder #(
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t      state;
  logic [31:0] skid_instr;
  logic        skid_err;
  logic [31:0] lw_w, sw_w, beq_w, enc_word;
  logic        range_bad, enc_bad, acc, hs;
  assign acc = in_valid & in_ready;
  assign hs  = out_valid & out_ready;
  assign lw_w  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
  assign sw_w  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
  assign beq_w = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
`ifdef ENC_RANGE_CHK_EN
  assign range_bad = (in_op == 2'b10)
    ? ($signed(in_imm) < -4096 || $signed(in_imm) > 4094 || in_imm[0])
    : ($signed(in_imm) < -2048 || $signed(in_imm) > 2047);
`else
  logic imm_unused;
  assign imm_unused = ^in_imm[31:13];
  assign range_bad  = 1'b0;
`endif
  assign enc_bad  = (in_op == 2'b11) | range_bad;
  assign enc_word = enc_bad ? 32'h0 : in_op == 2'b00 ? lw_w : in_op == 2'b01 ? sw_w : beq_w;
  // MAIN is the output register set; SKID only holds a word while stalled in TWO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_err    <= 1'b0;
      out_addr   <= ADDR_BASE;
      err        <= 1'b0;
      skid_instr <= 32'h0;
      skid_err   <= 1'b0;
    end else begin
      out_addr <= clr ? ADDR_BASE : hs ? out_addr + ADDR_STEP : out_addr;
      err      <= (err & ~clr) | (acc & enc_bad);
      case (state)
        EMPTY: if (acc) begin
          out_instr <= enc_word;
          out_err   <= enc_bad;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: if (acc && !hs) begin
          skid_instr <= enc_word;
          skid_err   <= enc_bad;
          in_ready   <= 1'b0;
          state      <= TWO;
        end else if (acc) begin
          out_instr <= enc_word;
          out_err   <= enc_bad;
        end else if (hs) begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
        TWO: if (hs) begin
          out_instr <= skid_instr;
          out_err   <= skid_err;
          in_ready  <= 1'b1;
          state     <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed RV32I words for instr_encoder.
module tb_instr_encoder;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'h0, out_instr, out_addr;
  logic        out_err, err;
  logic        w_in_ready, w_out_valid, w_out_err, w_err;
  logic [31:0] w_out_instr, w_out_addr;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  instr_encoder dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err(err)
  );
  instr_encoder #(.ADDR_BASE(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_addr(w_out_addr), .out_err(w_out_err), .err(w_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op = op;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    tick();
    req(2'b00, 5'd5, 5'd2, 5'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("lw_valid", {31'b0, out_valid}, 32'd1);
    chk("lw_instr", out_instr, 32'h0081_2283);
    chk("lw_addr", out_addr, 32'h0);
    tick();
    chk("lw_drained", {31'b0, out_valid}, 32'd0);
    chk("lw_addr_inc", out_addr, 32'd4);
    do_clr();
    chk("clr_addr", out_addr, 32'h0);
    req(2'b01, 5'd0, 5'd1, 5'd6, -32'sd4);
    tick();
    chk("sw_instr", out_instr, 32'hFE60_AE23);
    chk("sw_addr", out_addr, 32'h0);
    req(2'b10, 5'd0, 5'd1, 5'd2, -32'sd8);
    tick();
    in_valid = 1'b0;
    chk("beq_instr", out_instr, 32'hFE20_8CE3);
    chk("beq_addr", out_addr, 32'd4);
    chk("beq_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("b2b_drained", {31'b0, out_valid}, 32'd0);
    chk("b2b_addr", out_addr, 32'd8);
    do_clr();
    out_ready = 1'b0;
    req(2'b00, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    chk("bp_ready1", {31'b0, in_ready}, 32'd1);
    req(2'b00, 5'd2, 5'd0, 5'd0, 32'd0);
    tick();
    chk("bp_ready2", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_a", out_instr, 32'h0000_2083);
    req(2'b00, 5'd3, 5'd0, 5'd0, 32'd0);
    tick();
    chk("bp_ready3", {31'b0, in_ready}, 32'd0);
    chk("bp_stable_instr", out_instr, 32'h0000_2083);
    chk("bp_stable_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_instr", out_instr, 32'h0000_2103);
    chk("bp_b_addr", out_addr, 32'd4);
    chk("bp_ready4", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_instr", out_instr, 32'h0000_2183);
    chk("bp_c_addr", out_addr, 32'd8);
    tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);
    chk("bp_end_addr", out_addr, 32'd12);
    do_clr();
    out_ready = 1'b0;
    req(2'b11, 5'd1, 5'd1, 5'd1, 32'd4);
    tick();
    in_valid = 1'b0;
    chk("op11_instr", out_instr, 32'h0);
    chk("op11_out_err", {31'b0, out_err}, 32'd1);
    chk("op11_err", {31'b0, err}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("op11_err_sticky", {31'b0, err}, 32'd1);
    do_clr();
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_addr2", out_addr, 32'h0);
    clr = 1'b1;
    req(2'b11, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("clr_coincident_err", {31'b0, err}, 32'd1);
    tick();
    clr = 1'b0;
    chk("clr_over_inc_addr", out_addr, 32'h0);
    chk("clr_err2", {31'b0, err}, 32'd0);
    req(2'b00, 5'd5, 5'd2, 5'd0, 32'd2048);
    tick();
    req(2'b10, 5'd0, 5'd1, 5'd2, 32'd3);
`ifdef ENC_RANGE_CHK_EN
    chk("rng_lw_instr", out_instr, 32'h0);
    chk("rng_lw_out_err", {31'b0, out_err}, 32'd1);
`else
    chk("trunc_lw_instr", out_instr, 32'h8001_2283);
    chk("trunc_lw_out_err", {31'b0, out_err}, 32'd0);
`endif
    chk("rng_lw_addr", out_addr, 32'h0);
    tick();
    in_valid = 1'b0;
`ifdef ENC_RANGE_CHK_EN
    chk("rng_beq_instr", out_instr, 32'h0);
    chk("rng_beq_out_err", {31'b0, out_err}, 32'd1);
    chk("rng_err", {31'b0, err}, 32'd1);
`else
    chk("trunc_beq_instr", out_instr, 32'h0020_8163);
    chk("trunc_beq_out_err", {31'b0, out_err}, 32'd0);
    chk("trunc_err", {31'b0, err}, 32'd0);
`endif
    chk("rng_beq_addr", out_addr, 32'd4);
    tick();
    do_clr();
    chk("rng_clr_err", {31'b0, err}, 32'd0);
    chk("rng_clr_addr", out_addr, 32'h0);
    out_ready = 1'b0;
    req(2'b00, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    req(2'b00, 5'd2, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("two_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_addr", out_addr, 32'h0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    req(2'b00, 5'd5, 5'd2, 5'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("post_rst_instr", out_instr, 32'h0081_2283);
    chk("post_rst_addr", out_addr, 32'h0);
    chk("wrap_pre_addr", w_out_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", w_out_addr, 32'h0);
    chk("post_rst_addr_inc", out_addr, 32'd4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Packs decoded load/store/branch requests (op, register indices, signed byte immediate) into 32-bit RV32I instruction words. This is the inverse of the datapath's immediate sign-extender.
- Emits the words through a valid/ready stream with a running word address, so a test loader or boot sequencer can fill instruction memory.
- A 2-entry skid buffer holds results, giving full throughput with a registered IN_READY.

## Interface
Parameters:
- ADDR_STEP, 4, byte increment of OUT_ADDR per emitted word
- ADDR_BASE, 32'h0, OUT_ADDR value after reset/CLR

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- CLR  in  1  synchronous clear of OUT_ADDR and ERR (does not flush data)
- IN_VALID  in  1  request valid
- IN_READY  out  1  request accepted when IN_VALID & IN_READY at edge
- IN_OP  in  2  00 lw, 01 sw, 10 beq, 11 unsupported
- IN_RD  in  5  destination register (lw)
- IN_RS1  in  5  base/first source
- IN_RS2  in  5  store data / second compare source
- IN_IMM  in  32  signed byte offset
- OUT_VALID  out  1  OUT_INSTR valid
- OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY
- OUT_INSTR  out  32  encoded instruction
- OUT_ADDR  out  32  word address associated with OUT_INSTR
- OUT_ERR  out  1  this word came from an illegal request
- ERR  out  1  sticky: any illegal request accepted since reset/CLR

## Operation
Encoding, with i = IN_IMM:
- lw: {i[11:0], RS1, 3'b010, RD, 7'b0000011}
- sw: {i[11:5], RS2, RS1, 3'b010, i[4:0], 7'b0100011}
- beq: {i[12], i[10:5], RS2, RS1, 3'b000, i[4:1], i[11], 7'b1100011}
- The sign-extender returns bits [12:1] of the beq offset. Round trip: decode(encode(beq, i)) == i>>>1.
- op 11: word 32'h0, OUT_ERR=1, matching the decoder's zero default.

Skid buffer FSM (MAIN drives outputs, SKID holds overflow):
- EMPTY: OUT_VALID=0. On accept → ONE.
- ONE: on accept without output handshake → TWO (word into SKID). On accept with output handshake → ONE (MAIN reloads). On output handshake alone → EMPTY.
- TWO: IN_READY=0. On output handshake, SKID moves to MAIN → ONE.

Ordering and addressing:
- IN_READY = (state != TWO), registered. Ordering is strictly FIFO.
- OUT_ADDR holds the address of the word in MAIN. It advances by ADDR_STEP on each output handshake and wraps modulo 2^32.
- CLR forces OUT_ADDR=ADDR_BASE and ERR=0 next edge, overriding a coincident increment. An error accepted in the same cycle as CLR still sets ERR.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, OUT_INSTR=0, OUT_ADDR=ADDR_BASE, OUT_ERR=0, ERR=0, state EMPTY.
- RST mid-operation discards both buffered words immediately (asynchronous).
- Latency: a request accepted at edge N is visible on the outputs after edge N.
- Sustained throughput is 1 word/cycle with OUT_READY=1.
- OUT_INSTR, OUT_ADDR and OUT_ERR hold stable while OUT_VALID=1 and OUT_READY=0.
- ERR rises the edge after an illegal request is accepted, not when it is emitted.

## Configuration
- ENC_RANGE_CHK_EN defined:
  - Legal ranges: lw/sw require IN_IMM in [-2048, 2047]; beq requires IN_IMM in [-4096, 4094] and even.
  - A violating request is still accepted and occupies an address.
  - It is emitted as 32'h0 with OUT_ERR=1 and sets ERR.
- ENC_RANGE_CHK_EN undefined:
  - IN_IMM is silently truncated to the encoded bits.
  - Only op 11 produces OUT_ERR/ERR.

## Test plan
- lw rd=5, rs1=2, imm=8, OUT_READY=1 → OUT_INSTR=32'h00812283, OUT_ADDR=0, OUT_VALID one cycle after accept.
- sw rs2=6, rs1=1, imm=-4 then beq rs1=1, rs2=2, imm=-8 back-to-back → 32'hFE60AE23 @0, 32'hFE208CE3 @4.
- OUT_READY=0, three requests offered every cycle → IN_READY low after the 2nd accept. Release OUT_READY → words emerge in order at 0, 4, 8.
- With ENC_RANGE_CHK_EN: lw imm=2048, then beq imm=3 → both emitted 32'h0 with OUT_ERR=1, ERR=1. CLR → ERR=0, OUT_ADDR=0.
- Assert RST while in state TWO → OUT_VALID=0 and IN_READY=1 immediately. The next request is emitted at ADDR_BASE.
- Preload OUT_ADDR to 32'hFFFFFFFC via 2^30-1 handshakes (or forced), then emit one word → next OUT_ADDR = 0.
